// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and holds one fetched word for the IF pipeline register.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instructionOut,
    output logic [31:0] pcOut,
    output logic        validOut
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcout_reg, pcout_next;
    logic        valid_reg, valid_next;
    logic        consume;
    logic [31:0] pc_inc;

    assign consume = valid_reg & ~freeze;
    assign pc_inc  = pc_reg + STEP;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pcout_next = pcout_reg;
        valid_next = valid_reg;

        if (consume) begin
            valid_next = 1'b0;
            instr_next = 32'h0;
            pcout_next = 32'h0;
        end

        case (state_reg)
            IDLE: begin
                // Issue only when the buffer is empty or drains on this edge
                if (branchTaken) begin
                    pc_next = branchAddr;
                end else if (~valid_reg | ~freeze) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (branchTaken) begin
                    pc_next    = branchAddr;
                    state_next = imemAck ? IDLE : DROP;
                end else if (imemAck) begin
                    valid_next = 1'b1;
                    instr_next = imemData;
                    pcout_next = pc_inc;
                    pc_next    = pc_inc;
                    state_next = IDLE;
                end
            end
            DROP: begin
                // The outstanding ack belongs to a squashed fetch; its data is discarded
                if (branchTaken) begin
                    pc_next = branchAddr;
                end
                if (imemAck) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (branchTaken) begin
            valid_next = 1'b0;
            instr_next = 32'h0;
            pcout_next = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
            pcout_reg <= 32'h0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pcout_reg <= pcout_next;
            valid_reg <= valid_next;
        end
    end

    assign imemReq        = (state_reg != IDLE);
    assign imemAddr       = pc_reg;
    assign instructionOut = instr_reg;
    assign pcOut          = pcout_reg;
    assign validOut       = valid_reg;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios plus a randomized run against a
// transaction-level model (outstanding fetch + squash flag).
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instructionOut;
    logic [31:0] pcOut;
    logic        validOut;

    int passed = 0;
    int total  = 0;

    inst_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branchTaken(branchTaken),
        .branchAddr(branchAddr),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .instructionOut(instructionOut),
        .pcOut(pcOut),
        .validOut(validOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcout;
        logic        valid;
        logic        busy;
        logic        stale;
    } model_t;

    model_t m;

    // One fetch may be outstanding; a redirect marks it stale so its data is thrown away.
    function automatic model_t model_next(model_t s, logic br, logic [31:0] ba,
                                          logic ack, logic [31:0] d, logic fr);
        model_t n;
        logic   issue;
        n     = s;
        issue = !s.busy && !br && (!s.valid || !fr);
        if (s.valid && !fr) begin
            n.valid = 1'b0;
            n.instr = 32'h0;
            n.pcout = 32'h0;
        end
        if (s.busy && ack) begin
            if (!s.stale && !br) begin
                n.valid = 1'b1;
                n.instr = d;
                n.pcout = s.pc + 32'd4;
                n.pc    = s.pc + 32'd4;
            end
            n.busy = 1'b0;
        end
        if (issue) begin
            n.busy  = 1'b1;
            n.stale = 1'b0;
        end
        if (br) begin
            n.pc    = ba;
            n.valid = 1'b0;
            n.instr = 32'h0;
            n.pcout = 32'h0;
            n.stale = n.busy;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= model_next(m, branchTaken, branchAddr, imemAck, imemData, freeze);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (imemReq !== 1'b0) $display("FAIL reset_req: got %0h exp 0", imemReq); else passed++;
        total++; if (imemAddr !== 32'h0) $display("FAIL reset_addr: got %h exp 0", imemAddr); else passed++;
        total++; if ({validOut, instructionOut, pcOut} !== 65'h0)
            $display("FAIL reset_outs: got v=%0h i=%h p=%h exp zeros", validOut, instructionOut, pcOut); else passed++;
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic_fetch();
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'h0})
            $display("FAIL basic_req0: got req=%0h addr=%h exp 1/0", imemReq, imemAddr); else passed++;
        imemAck = 1'b1; imemData = 32'hE3A01005;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, instructionOut, pcOut} !== {1'b1, 32'hE3A01005, 32'h4})
            $display("FAIL basic_out: got v=%0h i=%h p=%h exp 1/e3a01005/4", validOut, instructionOut, pcOut); else passed++;
        total++; if (imemReq !== 1'b0) $display("FAIL basic_req_low: got %0h exp 0", imemReq); else passed++;
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'h4})
            $display("FAIL basic_req4: got req=%0h addr=%h exp 1/4", imemReq, imemAddr); else passed++;
        $display("test_basic_fetch done");
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        imemAck = 1'b1; imemData = 32'h1234_5678;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, instructionOut, pcOut} !== {1'b1, 32'h1234_5678, 32'h8})
            $display("FAIL freeze_load: got v=%0h i=%h p=%h exp 1/12345678/8", validOut, instructionOut, pcOut); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({imemReq, imemAddr, validOut, instructionOut, pcOut} !== {1'b0, 32'h8, 1'b1, 32'h1234_5678, 32'h8})
                $display("FAIL freeze_hold%0d: got r=%0h a=%h v=%0h i=%h p=%h exp 0/8/1/12345678/8",
                         i, imemReq, imemAddr, validOut, instructionOut, pcOut); else passed++;
        end
        freeze = 1'b0;
        @(negedge clk);
        total++; if ({imemReq, imemAddr, validOut, instructionOut, pcOut} !== {1'b1, 32'h8, 1'b0, 64'h0})
            $display("FAIL freeze_release: got r=%0h a=%h v=%0h i=%h p=%h exp 1/8/0/0/0",
                     imemReq, imemAddr, validOut, instructionOut, pcOut); else passed++;
        $display("test_freeze done");
    endtask

    task automatic test_branch_busy();
        branchTaken = 1'b1; branchAddr = 32'h100;
        @(negedge clk);
        branchTaken = 1'b0;
        total++; if ({imemReq, imemAddr, validOut} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL brbusy_redirect: got r=%0h a=%h v=%0h exp 1/100/0", imemReq, imemAddr, validOut); else passed++;
        @(negedge clk);
        imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({imemReq, validOut, instructionOut} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL brbusy_stale: got r=%0h v=%0h i=%h exp 0/0/0", imemReq, validOut, instructionOut); else passed++;
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'h100})
            $display("FAIL brbusy_req: got r=%0h a=%h exp 1/100", imemReq, imemAddr); else passed++;
        imemAck = 1'b1; imemData = 32'h1111_1111;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, instructionOut, pcOut} !== {1'b1, 32'h1111_1111, 32'h104})
            $display("FAIL brbusy_result: got v=%0h i=%h p=%h exp 1/11111111/104", validOut, instructionOut, pcOut); else passed++;
        $display("test_branch_busy done");
    endtask

    task automatic test_branch_ack();
        @(negedge clk);
        total++; if ({imemReq, imemAddr, validOut} !== {1'b1, 32'h104, 1'b0})
            $display("FAIL brack_pre: got r=%0h a=%h v=%0h exp 1/104/0", imemReq, imemAddr, validOut); else passed++;
        branchTaken = 1'b1; branchAddr = 32'h200; imemAck = 1'b1; imemData = 32'hBAD0_BAD0;
        @(negedge clk);
        branchTaken = 1'b0; imemAck = 1'b0;
        total++; if ({imemReq, imemAddr, validOut, instructionOut} !== {1'b0, 32'h200, 1'b0, 32'h0})
            $display("FAIL brack_same: got r=%0h a=%h v=%0h i=%h exp 0/200/0/0",
                     imemReq, imemAddr, validOut, instructionOut); else passed++;
        $display("test_branch_ack done");
    endtask

    task automatic test_branch_frozen();
        freeze = 1'b1;
        @(negedge clk);
        imemAck = 1'b1; imemData = 32'h2222_2222;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, pcOut} !== {1'b1, 32'h204})
            $display("FAIL brfrz_load: got v=%0h p=%h exp 1/204", validOut, pcOut); else passed++;
        branchTaken = 1'b1; branchAddr = 32'h300;
        @(negedge clk);
        branchTaken = 1'b0;
        total++; if ({imemReq, imemAddr, validOut, instructionOut, pcOut} !== {1'b0, 32'h300, 1'b0, 64'h0})
            $display("FAIL brfrz_clear: got r=%0h a=%h v=%0h i=%h p=%h exp 0/300/0/0/0",
                     imemReq, imemAddr, validOut, instructionOut, pcOut); else passed++;
        freeze = 1'b0;
        $display("test_branch_frozen done");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC; imemAck = 1'b1; imemData = 32'h0;
        @(negedge clk);
        branchTaken = 1'b0; imemAck = 1'b0;
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_req: got r=%0h a=%h exp 1/fffffffc", imemReq, imemAddr); else passed++;
        imemAck = 1'b1; imemData = 32'hCAFE_F00D;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, instructionOut, pcOut} !== {1'b1, 32'hCAFE_F00D, 32'h0})
            $display("FAIL wrap_out: got v=%0h i=%h p=%h exp 1/cafef00d/0", validOut, instructionOut, pcOut); else passed++;
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'h0})
            $display("FAIL wrap_next: got r=%0h a=%h exp 1/0", imemReq, imemAddr); else passed++;
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        imemAck = 1'b1; imemData = 32'h4444_4444;
        @(negedge clk);
        imemAck = 1'b0;
        @(negedge clk);
        total++; if ({imemReq, imemAddr} !== {1'b1, 32'h4})
            $display("FAIL rstmid_pre: got r=%0h a=%h exp 1/4", imemReq, imemAddr); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({imemReq, imemAddr, validOut, instructionOut, pcOut} !== 98'h0)
            $display("FAIL rstmid_async: got r=%0h a=%h v=%0h i=%h p=%h exp zeros",
                     imemReq, imemAddr, validOut, instructionOut, pcOut); else passed++;
        @(negedge clk);
        rst = 1'b1; imemAck = 1'b1; imemData = 32'h7777_7777;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({imemReq, imemAddr, validOut} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL rstmid_stray: got r=%0h a=%h v=%0h exp 1/0/0", imemReq, imemAddr, validOut); else passed++;
        imemAck = 1'b1; imemData = 32'h3333_3333;
        @(negedge clk);
        imemAck = 1'b0;
        total++; if ({validOut, instructionOut, pcOut} !== {1'b1, 32'h3333_3333, 32'h4})
            $display("FAIL rstmid_restart: got v=%0h i=%h p=%h exp 1/33333333/4", validOut, instructionOut, pcOut); else passed++;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int     cnt;
        int     fetched;
        logic [97:0] exp_v, got_v;
        cnt     = -1;
        fetched = 0;
        for (int i = 0; i < 1500; i++) begin
            freeze      = ($urandom_range(0, 9) < 3);
            branchTaken = ($urandom_range(0, 15) == 0);
            branchAddr  = $urandom() & 32'hFFFF_FFFC;
            imemData    = $urandom();
            imemAck     = 1'b0;
            if (imemReq) begin
                if (cnt < 0) cnt = int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    imemAck = 1'b1;
                    cnt     = -1;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                imemAck = 1'b1;
            end
            @(negedge clk);
            exp_v = {m.busy, m.pc, m.valid, m.instr, m.pcout};
            got_v = {imemReq, imemAddr, validOut, instructionOut, pcOut};
            total++;
            if (got_v !== exp_v)
                $display("FAIL random_cyc%0d: got r=%0h a=%h v=%0h i=%h p=%h exp r=%0h a=%h v=%0h i=%h p=%h",
                         i, imemReq, imemAddr, validOut, instructionOut, pcOut,
                         m.busy, m.pc, m.valid, m.instr, m.pcout);
            else passed++;
            if (validOut && !freeze) fetched++;
        end
        freeze = 1'b0; branchTaken = 1'b0; imemAck = 1'b0;
        $display("test_random done: %0d instructions consumed", fetched);
    endtask

    initial begin
        rst         = 1'b0;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0;
        imemAck     = 1'b0;
        imemData    = 32'h0;
        test_reset();
        test_basic_fetch();
        test_freeze();
        test_branch_busy();
        test_branch_ack();
        test_branch_frozen();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
